// File: rtl/gcd_ctrl_if.sv
// gcd_ctrl_if: request/response handshake bundle for the GCD controller.
//   in_valid  : requester -> ctrl, operand pair on op_a/op_b is valid
//   in_ready  : ctrl -> requester, controller can accept a pair
//   out_valid : ctrl -> consumer, datapath res is valid
//   out_ready : consumer -> ctrl, result taken
interface gcd_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  // controller side
  modport slave  (input in_valid, out_ready, output in_ready, out_valid);
  // requester / consumer side
  modport master (output in_valid, out_ready, input in_ready, out_valid);
endinterface

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for a subtract/swap GCD datapath.
//   clk, rst          : clock (rising edge), async active-high reset
//   bus (slave)       : in_valid/in_ready request, out_valid/out_ready response
//   A_B_lt_result     : datapath flag A < B
//   B_0_ne_result     : datapath flag B != 0
//   mux_A_select      : 00 op_a, 01 A-B, 10 B, 11 zero (unused)
//   mux_B_select      : 0 op_b, 1 A
//   reg_A_wen/B_wen   : datapath register write enables
//   busy              : high in CALC
//   iter_count        : CALC write cycles of current/last computation
//   timeout           : qualifies out_valid, result cut short at MAX_ITER
module gcd_ctrl #(
  parameter int CW       = 10,
  parameter int MAX_ITER = 1023   // must fit in CW bits
) (
  input  logic          clk,
  input  logic          rst,
  gcd_ctrl_if.slave     bus,
  input  logic          A_B_lt_result,
  input  logic          B_0_ne_result,
  output logic [1:0]    mux_A_select,
  output logic          mux_B_select,
  output logic          reg_A_wen,
  output logic          reg_B_wen,
  output logic          busy,
  output logic [CW-1:0] iter_count,
  output logic          timeout
);

  localparam logic [1:0] SEL_A_OP  = 2'b00;
  localparam logic [1:0] SEL_A_SUB = 2'b01;
  localparam logic [1:0] SEL_A_B   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_iter,  w_iter_nxt;
  logic          r_timeout, w_to_nxt;
  logic          w_run;   // datapath would still do a swap or subtract

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_iter    <= w_iter_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_iter_nxt    = r_iter;
    w_to_nxt      = r_timeout;
    mux_A_select  = SEL_A_OP;
    mux_B_select  = 1'b0;
    reg_A_wen     = 1'b0;
    reg_B_wen     = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    w_run         = A_B_lt_result | B_0_ne_result;

    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // Mealy load of op_a/op_b in the accepting cycle
          reg_A_wen  = 1'b1;
          reg_B_wen  = 1'b1;
          w_iter_nxt = '0;
          w_to_nxt   = 1'b0;
          w_next     = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        // Budget check first so iter_count can never pass MAX_ITER
        if (r_iter == CW'(MAX_ITER) && w_run) begin
          w_to_nxt = 1'b1;
          w_next   = S_DONE;
        end else if (A_B_lt_result) begin
          mux_A_select = SEL_A_B;
          mux_B_select = 1'b1;
          reg_A_wen    = 1'b1;
          reg_B_wen    = 1'b1;
          w_iter_nxt   = r_iter + CW'(1);
        end else if (B_0_ne_result) begin
          mux_A_select = SEL_A_SUB;
          reg_A_wen    = 1'b1;
          w_iter_nxt   = r_iter + CW'(1);
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // The state register is already IDLE under reset, but the IDLE Mealy
    // load would still fire from in_valid; hold everything quiet instead.
    if (rst) begin
      mux_A_select  = SEL_A_OP;
      mux_B_select  = 1'b0;
      reg_A_wen     = 1'b0;
      reg_B_wen     = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
    end
  end

  assign iter_count = r_iter;
  assign timeout    = r_timeout;

  // Handshake inputs must be known whenever the FSM looks at them.
  a_in_valid_known: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_IDLE) |-> !$isunknown(bus.in_valid));
  a_out_ready_known: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_DONE) |-> !$isunknown(bus.out_ready));

endmodule

// File: tb/tb_gcd_ctrl.sv
module tb_gcd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 0: default MAX_ITER ----------------
  gcd_ctrl_if bus0();
  logic        iv0 = 1'b0, ordy0 = 1'b0;
  logic [1:0]  sa0;
  logic        sb0, wa0, wb0, bsy0, to0;
  logic [9:0]  ic0;
  logic [15:0] opa0 = '0, opb0 = '0, ra0 = '0, rb0 = '0;
  logic        lt0, ne0;
  assign bus0.in_valid  = iv0;
  assign bus0.out_ready = ordy0;

  gcd_ctrl #(.CW(10), .MAX_ITER(1023)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .A_B_lt_result(lt0), .B_0_ne_result(ne0),
    .mux_A_select(sa0), .mux_B_select(sb0),
    .reg_A_wen(wa0), .reg_B_wen(wb0),
    .busy(bsy0), .iter_count(ic0), .timeout(to0));

  // datapath model
  always_ff @(posedge clk) begin
    if (wa0) ra0 <= (sa0 == 2'b00) ? opa0 : (sa0 == 2'b01) ? ra0 - rb0 : (sa0 == 2'b10) ? rb0 : 16'd0;
    if (wb0) rb0 <= sb0 ? ra0 : opb0;
  end
  assign lt0 = ra0 < rb0;
  assign ne0 = rb0 != 16'd0;

  // ---------------- DUT 1: MAX_ITER = 4 ----------------
  gcd_ctrl_if bus1();
  logic        iv1 = 1'b0, ordy1 = 1'b0;
  logic [1:0]  sa1;
  logic        sb1, wa1, wb1, bsy1, to1;
  logic [9:0]  ic1;
  logic [15:0] opa1 = '0, opb1 = '0, ra1 = '0, rb1 = '0;
  logic        lt1, ne1;
  assign bus1.in_valid  = iv1;
  assign bus1.out_ready = ordy1;

  gcd_ctrl #(.CW(10), .MAX_ITER(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .A_B_lt_result(lt1), .B_0_ne_result(ne1),
    .mux_A_select(sa1), .mux_B_select(sb1),
    .reg_A_wen(wa1), .reg_B_wen(wb1),
    .busy(bsy1), .iter_count(ic1), .timeout(to1));

  always_ff @(posedge clk) begin
    if (wa1) ra1 <= (sa1 == 2'b00) ? opa1 : (sa1 == 2'b01) ? ra1 - rb1 : (sa1 == 2'b10) ? rb1 : 16'd0;
    if (wb1) rb1 <= sb1 ? ra1 : opb1;
  end
  assign lt1 = ra1 < rb1;
  assign ne1 = rb1 != 16'd0;

  // {mux_A_select, mux_B_select, reg_A_wen, reg_B_wen}
  wire [4:0] ctl0 = {sa0, sb0, wa0, wb0};
  localparam logic [4:0] C_SUB  = 5'b01_0_1_0;
  localparam logic [4:0] C_SWAP = 5'b10_1_1_1;
  localparam logic [4:0] C_LOAD = 5'b00_0_1_1;
  localparam logic [4:0] C_NONE = 5'b00_0_0_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a pair in an idle cycle; returns #1 after the accepting edge.
  task automatic accept0(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    opa0 = a; opb0 = b; iv0 = 1'b1;
    #1;
    chk("idle_ready", 32'(bus0.in_ready), 32'd1);
    chk("load_ctl", 32'(ctl0), 32'(C_LOAD));
    @(posedge clk); #1;
    iv0 = 1'b0;
    chk("iter_cleared", 32'(ic0), 32'd0);
    chk("busy_calc", 32'(bsy0), 32'd1);
  endtask

  // Wait for out_valid, counting edges after the accept.
  task automatic wait_done0(output int n);
    n = 0;
    while (!bus0.out_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release0;
    ordy0 = 1'b1;
    @(posedge clk); #1;
    ordy0 = 1'b0;
    chk("rel_valid", 32'(bus0.out_valid), 32'd0);
    chk("rel_ready", 32'(bus0.in_ready), 32'd1);
  endtask

  task automatic run0(input logic [15:0] a, input logic [15:0] b,
                      input int exp_res, input int exp_iter, input string tag);
    int n;
    accept0(a, b);
    wait_done0(n);
    chk({tag, "_lat"},  32'(n), 32'(exp_iter + 1));
    chk({tag, "_res"},  32'(ra0), 32'(exp_res));
    chk({tag, "_iter"}, 32'(ic0), 32'(exp_iter));
    chk({tag, "_to"},   32'(to0), 32'd0);
    release0();
  endtask

  initial begin
    logic [4:0] seq [6];
    int n;
    seq = '{C_SUB, C_SWAP, C_SUB, C_SUB, C_SWAP, C_NONE};

    // Reset: in_valid high must not leak into the load enables.
    iv0 = 1'b1;
    #1;
    chk("rst_wen", 32'(ctl0), 32'(C_NONE));
    chk("rst_ready", 32'(bus0.in_ready), 32'd0);
    chk("rst_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_iter", 32'(ic0), 32'd0);
    chk("rst_to", 32'(to0), 32'd0);
    iv0 = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ready", 32'(bus0.in_ready), 32'd1);
    chk("post_rst_busy", 32'(bsy0), 32'd0);
    chk("post_rst_valid", 32'(bus0.out_valid), 32'd0);

    // (12,8): sub, swap, sub, sub, swap, then B==0 terminate
    accept0(16'd12, 16'd8);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("seq%0d", k), 32'(ctl0), 32'(seq[k]));
    end
    @(posedge clk); #1;   // sixth edge after accept
    chk("t1_valid", 32'(bus0.out_valid), 32'd1);
    chk("t1_res", 32'(ra0), 32'd4);
    chk("t1_iter", 32'(ic0), 32'd5);
    chk("t1_to", 32'(to0), 32'd0);

    // Stall in DONE while poking in_valid with other operands.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      iv0 = k[0]; opa0 = 16'd99; opb0 = 16'd7;
      #1;
      chk("hold_valid", 32'(bus0.out_valid), 32'd1);
      chk("hold_ready", 32'(bus0.in_ready), 32'd0);
      chk("hold_wen", 32'({wa0, wb0}), 32'd0);
      chk("hold_res", 32'(ra0), 32'd4);
      chk("hold_iter", 32'(ic0), 32'd5);
    end
    @(negedge clk); iv0 = 1'b0;
    release0();

    run0(16'd0, 16'd0, 0, 0, "zz");   // immediate terminate
    run0(16'd0, 16'd5, 5, 1, "z5");   // single swap

    // Back-to-back. (255,1): 255 subtracts reach A=0, then one swap -> 256.
    // (17,51): swap, sub, sub, sub, swap -> 5. accept0 checks the clear.
    run0(16'd255, 16'd1, 1, 256, "b1");
    run0(16'd17, 16'd51, 17, 5, "b2");

    // Timeout on the MAX_ITER=4 instance: 4 writes then the budget trips.
    @(negedge clk);
    opa1 = 16'd12; opb1 = 16'd8; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("to_busy", 32'(bsy1), 32'd1);
    chk("to_term_wen", 32'({sa1, sb1, wa1, wb1}), 32'(C_NONE));
    @(posedge clk); #1;
    chk("to_valid", 32'(bus1.out_valid), 32'd1);
    chk("to_flag", 32'(to1), 32'd1);
    chk("to_iter", 32'(ic1), 32'd4);
    chk("to_res", 32'(ra1), 32'd0);
    ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;
    chk("to_rel_ready", 32'(bus1.in_ready), 32'd1);

    // Reset mid-CALC on (200,3).
    accept0(16'd200, 16'd3);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_wen", 32'(wa0), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_wen", 32'({wa0, wb0}), 32'd0);
    chk("mid_rst_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("after_rst_ready", 32'(bus0.in_ready), 32'd1);
    chk("after_rst_iter", 32'(ic0), 32'd0);
    chk("after_rst_busy", 32'(bsy0), 32'd0);
    // (9,6): sub, swap, sub, sub, swap -> res 3
    run0(16'd9, 16'd6, 3, 5, "r96");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
